alu_multicycle: RTL and testbench

Parametrised, handshaked successor of the single-cycle datapath ALU. Adds SRA/SLT/SLTU and iterative unsigned multiply/divide (MUL, MULHU, DIVU, REMU) behind a valid/ready interface with a registered result. It sits in the execute stage and stalls issue through `in_ready` while an iterative operation runs.

---
 rtl/alu_multicycle.sv | 117 +++++++++++
 tb/tb_alu_multicycle.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked execute-stage ALU. Single-cycle ops register
// their result in one cycle; MUL/MULHU/DIVU/REMU iterate for WIDTH cycles
// (shift-add multiply, restoring divide) while in_ready stalls issue.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CNTW = SHW + 1;

  logic [1:0]         state;
  logic [2*WIDTH-1:0] acc, acc_nx;   // {hi, lo}: product or {remainder, quotient}
  logic [WIDTH-1:0]   opb;           // multiplicand / divisor
  logic [WIDTH-1:0]   single_res;
  logic [CNTW-1:0]    cnt;
  logic               is_div, hi_sel;
  logic               hs, iter_op, last;
  logic [WIDTH:0]     sum, trial;
  logic [WIDTH-1:0]   diff;
  logic               ge;

  // DONE accepts a new request only when the current result is being consumed
  assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign hs        = in_valid && in_ready;
  assign iter_op   = (alu_ctrl >= 4'b1010) && (alu_ctrl <= 4'b1101);
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_CALC);
  assign zero      = (result == '0);
  assign last      = (cnt == CNTW'(WIDTH - 1));

  // single-cycle datapath, evaluated on the live inputs at handshake
  always_comb begin
    single_res = '0;
    case (alu_ctrl)
      4'b0000: single_res = a + b;
      4'b0001: single_res = a - b;
      4'b0010: single_res = a & b;
      4'b0011: single_res = a | b;
      4'b0100: single_res = a ^ b;
      4'b0101: single_res = a << b[SHW-1:0];
      4'b0110: single_res = a >> b[SHW-1:0];
      4'b0111: single_res = $signed(a) >>> b[SHW-1:0];
      4'b1000: single_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b1001: single_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: single_res = '0;
    endcase
  end

  // one multiply or divide step; both start from acc = {0, a}, opb = b.
  // Divide by zero falls out naturally: every trial succeeds, so the
  // quotient is all ones and the remainder ends up equal to a.
  always_comb begin
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge    = (trial >= {1'b0, opb});
    diff  = trial[WIDTH-1:0] - opb;   // fits: remainder stays below divisor
    if (is_div) begin
      if (ge) acc_nx = {diff, acc[WIDTH-2:0], 1'b1};
      else    acc_nx = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_nx = {sum, acc[WIDTH-1:1]};
    end
  end

  // control FSM, operand capture, iteration and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      acc    <= '0;
      opb    <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      hi_sel <= 1'b0;
      result <= '0;
    end else if (state == S_CALC) begin
      acc <= acc_nx;
      cnt <= cnt + 1'b1;
      if (last) begin
        result <= hi_sel ? acc_nx[2*WIDTH-1:WIDTH] : acc_nx[WIDTH-1:0];
        state  <= S_DONE;
      end
    end else if (hs) begin
      if (iter_op) begin
        acc    <= {{WIDTH{1'b0}}, a};
        opb    <= b;
        cnt    <= '0;
        is_div <= alu_ctrl[2];
        hi_sel <= alu_ctrl[0];
        state  <= S_CALC;
      end else begin
        result <= single_res;
        state  <= S_DONE;
      end
    end else if ((state == S_DONE) && out_ready) begin
      state <= S_IDLE;
    end else if ((state != S_IDLE) && (state != S_DONE)) begin
      state <= S_IDLE;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: table-driven check of every op plus hand sequences for
// streaming, backpressure and reset in the middle of an iterative op.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, zero, busy;
  logic [31:0] a, b, result;
  logic [3:0]  alu_ctrl;

  int checks = 0;
  int errors = 0;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_ctrl(alu_ctrl), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one op, then wait (bounded) for out_valid; sampled 1 time unit
  // after each rising edge. Inputs are scrambled after capture.
  task automatic do_op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output int bcnt, output int rdy);
    alu_ctrl = c; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~x; b = ~y; alu_ctrl = 4'h0;
    lat = 1; bcnt = 0; rdy = 0;
    while (!out_valid && lat < 100) begin
      if (busy) bcnt++;
      if (in_ready) rdy++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, rdy, nvalid;
    logic iter;

    tbl[0]  = '{4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000};
    tbl[1]  = '{4'h1, 32'h00000005, 32'h00000005, 32'h00000000};
    tbl[2]  = '{4'h2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
    tbl[3]  = '{4'h3, 32'h0000000F, 32'h000000F0, 32'h000000FF};
    tbl[4]  = '{4'h4, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00};
    tbl[5]  = '{4'h5, 32'h00000001, 32'h0000001F, 32'h80000000};
    tbl[6]  = '{4'h6, 32'h80000000, 32'h00000004, 32'h08000000};
    tbl[7]  = '{4'h7, 32'h80000000, 32'h00000024, 32'hF8000000};
    tbl[8]  = '{4'h8, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
    tbl[9]  = '{4'h9, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    tbl[10] = '{4'hE, 32'h00000005, 32'h00000006, 32'h00000000};
    tbl[11] = '{4'hA, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    tbl[12] = '{4'hB, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    tbl[13] = '{4'hA, 32'h00012345, 32'h00001000, 32'h12345000};
    tbl[14] = '{4'hC, 32'd100,      32'd7,        32'd14};
    tbl[15] = '{4'hD, 32'd100,      32'd7,        32'd2};
    tbl[16] = '{4'hC, 32'd9,        32'd0,        32'hFFFFFFFF};
    tbl[17] = '{4'hD, 32'd9,        32'd0,        32'd9};
    tbl[18] = '{4'hB, 32'h80000000, 32'h00000004, 32'h00000002};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; alu_ctrl = '0;
    #12;
    check("rst out_valid", out_valid, 0);
    check("rst in_ready", in_ready, 1);
    check("rst result", result, 0);
    check("rst zero", zero, 1);
    check("rst busy", busy, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 19; i++) begin
      iter = (tbl[i].ctrl >= 4'hA) && (tbl[i].ctrl <= 4'hD);
      do_op(tbl[i].ctrl, tbl[i].a, tbl[i].b, lat, bcnt, rdy);
      check($sformatf("vec%0d result", i), result, tbl[i].exp);
      check($sformatf("vec%0d zero", i), zero, (tbl[i].exp == 0));
      check($sformatf("vec%0d latency", i), lat, iter ? 33 : 1);
      check($sformatf("vec%0d busy cycles", i), bcnt, iter ? 32 : 0);
      check($sformatf("vec%0d in_ready in calc", i), rdy, 0);
      @(posedge clk); #1;   // DONE -> IDLE
    end

    // stream 4 ADDs: one result per cycle
    for (int i = 0; i < 4; i++) begin
      alu_ctrl = 4'h0; a = 32'(i * 10); b = 32'(i + 1); in_valid = 1'b1;
      @(posedge clk); #1;
      check($sformatf("stream%0d valid", i), out_valid, 1);
      check($sformatf("stream%0d result", i), result, 32'(i * 11 + 1));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("stream idle", out_valid, 0);

    // backpressure on a DIVU, with a pending ADD waiting on in_ready
    out_ready = 1'b0;
    do_op(4'hC, 32'd1000, 32'd10, lat, bcnt, rdy);
    check("bp divu latency", lat, 33);
    alu_ctrl = 4'h0; a = 32'd1; b = 32'd1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d result", k), result, 32'd100);
      check($sformatf("bp%0d valid", k), out_valid, 1);
      check($sformatf("bp%0d in_ready", k), in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp next valid", out_valid, 1);
    check("bp next result", result, 32'd2);
    @(posedge clk); #1;
    check("bp idle", out_valid, 0);

    // reset at iteration 10 of a MUL
    alu_ctrl = 4'hA; a = 32'h1234; b = 32'h5678; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid rst out_valid", out_valid, 0);
    check("mid rst in_ready", in_ready, 1);
    check("mid rst busy", busy, 0);
    check("mid rst result", result, 0);
    check("mid rst zero", zero, 1);
    @(negedge clk); rst = 1'b0;
    nvalid = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) nvalid++;
    end
    check("no valid after rst", nvalid, 0);
    do_op(4'h0, 32'd2, 32'd3, lat, bcnt, rdy);
    check("post rst add", result, 32'd5);
    check("post rst latency", lat, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
